// File: rtl/ram8_bank.sv
// Eight-word register bank: demuxed load, 8-way read mux and a self-timed clear sweep.
// Optional macro RAM8_WRITE_THROUGH_EN: in IDLE, a pending load bypasses its data to out.
module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             state_o,
  output logic [2:0]       cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [7:0]       load_en;
  logic [7:0]       zero_en;
  logic             write_ok;

  // A write is only accepted in IDLE, and a same-edge clear request wins.
  assign write_ok = (state_q == IDLE) && load && !clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_en = '0;
    zero_en = '0;
    for (int k = 0; k < 8; k++) begin
      load_en[k] = write_ok && (address == 3'(k));
    end
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SWEEP;
          cnt_d   = 3'd0;
        end
      end
      SWEEP: begin
        for (int k = 0; k < 8; k++) begin
          zero_en[k] = (cnt_q == 3'(k));
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (zero_en[k]) begin
          mem_q[k] <= '0;
        end else if (load_en[k]) begin
          mem_q[k] <= in;
        end
      end
    end
  end

`ifdef RAM8_WRITE_THROUGH_EN
  assign out = write_ok ? in : mem_q[address];
`else
  assign out = mem_q[address];
`endif

  assign busy    = (state_q == SWEEP);
  assign state_o = state_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_ram8_bank.sv
// Directed bench for ram8_bank: vector table for write/read-back plus hand sequences
// for reset, clear sweep, clr/load collisions, reset mid-sweep and the bypass path.
`timescale 1ns/1ps
module tb_ram8_bank;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] in;
  logic [2:0]   address;
  logic         load;
  logic         clr;
  logic [W-1:0] out;
  logic         busy;
  logic         state_o;
  logic [2:0]   cnt_o;

  int n_cmp;
  int n_bad;

  ram8_bank #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .address (address),
    .load    (load),
    .clr     (clr),
    .out     (out),
    .busy    (busy),
    .state_o (state_o),
    .cnt_o   (cnt_o)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic         clr;
    logic [2:0]   addr;
    logic [W-1:0] din;
    logic [W-1:0] exp_out;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    load = 1'b1; clr = 1'b0; address = a; in = d;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("wait_idle_busy", {15'd0, busy}, 16'h0000);
  endtask

  initial begin
    logic [W-1:0] exp_byp;
    int busy_cycles;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; in = '0; address = '0; load = 1'b0; clr = 1'b0;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #0.1;
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.05;
      check($sformatf("reset_word%0d", k), out, 16'h0000);
    end
    check("reset_busy", {15'd0, busy}, 16'h0000);
    check("reset_cnt", {13'd0, cnt_o}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: write 0x1111*k to word k, then read all back.
    for (int k = 0; k < 8; k++) begin
      vecs[k]     = '{1'b1, 1'b0, 3'(k), W'(16'h1111 * k), W'(16'h1111 * k), 1'b0};
      vecs[k + 8] = '{1'b0, 1'b0, 3'(k), 16'h0000,          W'(16'h1111 * k), 1'b0};
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load = vecs[i].load; clr = vecs[i].clr; address = vecs[i].addr; in = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].exp_busy});
    end
    @(negedge clk);
    load = 1'b0;

    // clr and load on the same IDLE edge: clr wins.
    @(negedge clk);
    load = 1'b1; clr = 1'b1; address = 3'd3; in = 16'hBEEF;
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b0;
    check("wc_busy", {15'd0, busy}, 16'h0001);
    check("wc_word3", out, 16'h3333);
    wait_idle();
    check("wc_word3_cleared", out, 16'h0000);

    // Clear sweep over all-ones with load held and a stray clr mid-sweep.
    for (int k = 0; k < 8; k++) write_word(3'(k), 16'hFFFF);
    @(negedge clk);
    clr = 1'b1; address = 3'd0;
    @(posedge clk); #1;
    clr = 1'b0;
    busy_cycles = busy ? 1 : 0;
    check("sw_start_word0", out, 16'hFFFF);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      load = 1'b1; in = 16'hAAAA; address = 3'(j);
      clr = (j == 2);
      @(posedge clk); #1;
      load = 1'b0; clr = 1'b0;
      if (busy) busy_cycles++;
      #0.1;
      check($sformatf("sw_word%0d_zero", j), out, 16'h0000);
      if (j < 7) begin
        address = 3'(j + 1);
        #0.1;
        check($sformatf("sw_word%0d_old", j + 1), out, 16'hFFFF);
      end
    end
    check("sw_busy_cycles", 16'(busy_cycles), 16'd8);
    check("sw_end_busy", {15'd0, busy}, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.1;
      check($sformatf("sw_after_word%0d", k), out, 16'h0000);
    end

    // Reset in the middle of a sweep.
    for (int k = 0; k < 8; k++) write_word(3'(k), 16'h0F0F + 16'(k));
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    address = 3'd7;
    #0.1;
    check("rs_pre_word7", out, 16'h0F16);
    #1 rst = 1'b1;
    #0.1;
    check("rs_busy", {15'd0, busy}, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.1;
      check($sformatf("rs_word%0d", k), out, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    write_word(3'd5, 16'h1234);
    address = 3'd5;
    #0.1;
    check("rs_write5", out, 16'h1234);
    address = 3'd4;
    #0.1;
    check("rs_word4", out, 16'h0000);

    // Write-through bypass (or its absence) before the edge.
    write_word(3'd2, 16'h0001);
`ifdef RAM8_WRITE_THROUGH_EN
    exp_byp = 16'h5A5A;
`else
    exp_byp = 16'h0001;
`endif
    @(negedge clk);
    load = 1'b1; address = 3'd2; in = 16'h5A5A;
    #1;
    check("byp_before_edge", out, exp_byp);
    @(posedge clk); #1;
    load = 1'b0;
    #0.1;
    check("byp_after_edge", out, 16'h5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram8_bank.md
Name: ram8_bank

Overview:
- Eight-word register bank, the consumer of the load-decode demux tree.
- A 1-bit load is demultiplexed by a 3-bit address onto eight word registers.
- Read-out passes through an 8-way mux tree.
- Adds a self-timed clear sweep with a busy flag, so memory can be zeroed without a global reset.
- Building block for the larger RAM64/RAM512 stages.

Parameters:
- WIDTH, 16, data word width in bits (min 1).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; asynchronous, active-high; clears all words, FSM and counter.
- in  input  WIDTH  write data.
- address  input  3  word select for both read and write.
- load  input  1  write strobe; sampled on rising clk edge.
- clr  input  1  clear-sweep request; single-cycle pulse or level, sampled on rising clk edge.
- out  output  WIDTH  read data = word[address], combinational.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset:
  - rst high immediately forces all 8 words to 0, state to IDLE, sweep counter to 0 and busy to 0.
  - out therefore reads 0 without waiting for a clock edge.
  - Release is synchronous to the next edge in the usual way.
- Read:
  - out = word[address], combinational, zero cycles latency.
  - Reads are allowed in every state, including during the sweep.
- Write, IDLE only:
  - On a rising edge with load=1 and clr=0, word[address] <= in.
  - Exactly one word updates; the other 7 hold.
  - A new value is visible on out from the cycle after the edge.
- Load decode:
  - Functionally equal to the 1-to-8 demux of load by address.
  - Only the selected word's enable can be high.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: rising edge with clr=1. cnt <= 0, busy goes high from the next cycle.
  - In SWEEP, each edge writes 0 to word[cnt] and then cnt <= cnt+1.
  - SWEEP -> IDLE: on the edge that clears word 7. cnt wraps to 0 and busy drops.
  - Busy is high for exactly 8 cycles.
- Simultaneous and boundary cases:
  - clr and load on the same IDLE edge: clr wins and the write is dropped.
  - load while busy: ignored, no word changes.
  - clr while busy: ignored; the sweep does not restart and its length is unchanged.
  - Sweep progress: words with index < cnt already read 0; the others still hold old data.
  - rst mid-sweep: all words are 0 at once, the FSM returns to IDLE and busy=0.
  - Address values 0..7 are all valid; there is no out-of-range case.
- Width rules: there is no arithmetic on data; the counter is 3 bits with natural wrap 7->0.

Optional Feature:
- Macro: RAM8_WRITE_THROUGH_EN.
- Defined:
  - When load=1, clr=0 and the FSM is in IDLE, out = in combinationally in the same cycle (write-through bypass).
  - In all other cases out = word[address].
- Undefined: out is always word[address]; the written value appears only after the edge.
- Storage behaviour is identical either way.

Test Plan:
- Reset values: assert rst mid-cycle with no clk edge -> out=0x0000 for address 0..7 and busy=0.
- Write then read back:
  - Write 0x1111*k to address k for k=0..7, one per cycle.
  - Then sweep address 0..7 -> out=0x0000,0x1111,...,0x7777.
  - No cross-writes occur.
- Write/clear on the same edge: load=1, clr=1, address=3, in=0xBEEF -> word3 unchanged and busy=1 next cycle.
- Clear sweep:
  - Preload all words with 0xFFFF, then pulse clr.
  - busy is high exactly 8 cycles, and word k reads 0 from the cycle after the k-th sweep edge.
  - load=1 with in=0xAAAA held throughout the sweep writes nothing.
- Reset mid-sweep: pulse clr and wait 3 edges, then assert rst -> all words 0, busy=0. A following write of 0x1234 to address 5 succeeds.
- Optional bypass:
  - With RAM8_WRITE_THROUGH_EN, word2=0x0001, load=1, address=2, in=0x5A5A -> out=0x5A5A before the edge.
  - Without the macro, out=0x0001 before the edge and 0x5A5A after it.
